// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register-initialisation sequencer.
package i2c_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StFetch,
    StBegin,
    StWait,
    StWstop,
    StGap,
    StFail,
    StDone,
    StErr
  } seq_state_e;

  // One-cycle event pulses returned by the I2C master.
  typedef struct packed {
    logic start;
    logic ack;
    logic nack;
    logic stop;
  } i2c_flags_t;

  localparam logic I2C_WR = 1'b0;

endpackage

// File: rtl/i2c_init_seq.sv
// Walks a {reg_addr, reg_data} table and issues one 2-byte I2C write per entry,
// retrying on NACK/timeout, then raises init_finish (or error).
module i2c_init_seq
  import i2c_pkg::*;
#(
  parameter logic [7:0]  SLAVE_ADDR = 8'h42,
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned GAP_CYC    = 200,
  parameter int unsigned MAX_RETRY  = 3,
  parameter int unsigned TIMEOUT    = 20000,
  parameter bit          AUTO_START = 1'b1,
  localparam int unsigned AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic [AW-1:0] tbl_addr,
  input  logic [15:0]   tbl_data,
  output logic [7:0]    slave_addr,
  output logic          i2c_rw,
  output logic          i2c_begin,
  output logic          conti_write,
  output logic [7:0]    write_data,
  output logic          write_en,
  input  logic          flag_start,
  input  logic          flag_ack,
  input  logic          flag_nack,
  input  logic          flag_stop,
  output logic          busy,
  output logic          init_finish,
  output logic          error,
  output logic [AW-1:0] err_index
);

  localparam int unsigned CNT_MAX = (TIMEOUT > GAP_CYC) ? TIMEOUT : GAP_CYC;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned RW      = $clog2(MAX_RETRY + 2);

  localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [AW-1:0] IDX_LAST  = AW'(NUM_REGS - 1);

  seq_state_e    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d, eidx_q, eidx_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    ackcnt_q, ackcnt_d;
  logic [7:0]    ra_q, ra_d, rd_q, rd_d, wdata_q, wdata_d;
  logic          redo_q, redo_d, we_q, we_d, conti_q, conti_d;
  logic          fin_q, fin_d, err_q, err_d;
  i2c_flags_t    flags;
  logic          any_flag;

  assign flags    = {flag_start, flag_ack, flag_nack, flag_stop};
  assign any_flag = |flags;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    eidx_d   = eidx_q;
    retry_d  = retry_q;
    cnt_d    = cnt_q;
    ackcnt_d = ackcnt_q;
    ra_d     = ra_q;
    rd_d     = rd_q;
    wdata_d  = wdata_q;
    redo_d   = redo_q;
    we_d     = 1'b0;
    conti_d  = conti_q;
    fin_d    = fin_q;
    err_d    = err_q;
    case (state_q)
      StIdle: if (AUTO_START || start) state_d = StFetch;
      StFetch: state_d = StBegin;
      // ROM data for idx is valid during the begin cycle.
      StBegin: begin
        ra_d     = tbl_data[15:8];
        rd_d     = tbl_data[7:0];
        ackcnt_d = '0;
        cnt_d    = '0;
        state_d  = StWait;
      end
      StWait: begin
        if (flags.nack) begin
          state_d = StFail;
        end else if (flags.ack) begin
          cnt_d = '0;
          unique case (ackcnt_q)
            2'd0: begin
              we_d = 1'b1; wdata_d = ra_q; conti_d = 1'b1; ackcnt_d = 2'd1;
            end
            2'd1: begin
              we_d = 1'b1; wdata_d = rd_q; conti_d = 1'b0; ackcnt_d = 2'd2;
            end
            default: state_d = StWstop;
          endcase
        end else if (any_flag) begin
          cnt_d = '0;
        end else if (cnt_q == TMO_LAST) begin
          state_d = StFail;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWstop: begin
        if (flags.stop) begin
          cnt_d   = '0;
          redo_d  = 1'b0;
          state_d = StGap;
        end else if (any_flag) begin
          cnt_d = '0;
        end else if (cnt_q == TMO_LAST) begin
          state_d = StFail;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StFail: begin
        cnt_d = '0;
        if (retry_q < RETRY_MAX) begin
          retry_d = retry_q + 1'b1;
          redo_d  = 1'b1;
          state_d = StGap;
        end else begin
          err_d   = 1'b1;
          eidx_d  = idx_q;
          state_d = StErr;
        end
      end
      StGap: begin
        if (cnt_q != GAP_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else if (redo_q) begin
          state_d = StFetch;
        end else if (idx_q == IDX_LAST) begin
          fin_d   = 1'b1;
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 1'b1;
          retry_d = '0;
          state_d = StFetch;
        end
      end
      StDone, StErr: begin
        if (start) begin
          idx_d   = '0;
          retry_d = '0;
          eidx_d  = '0;
          fin_d   = 1'b0;
          err_d   = 1'b0;
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      eidx_q   <= '0;
      retry_q  <= '0;
      cnt_q    <= '0;
      ackcnt_q <= '0;
      ra_q     <= '0;
      rd_q     <= '0;
      wdata_q  <= '0;
      redo_q   <= 1'b0;
      we_q     <= 1'b0;
      conti_q  <= 1'b0;
      fin_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      eidx_q   <= eidx_d;
      retry_q  <= retry_d;
      cnt_q    <= cnt_d;
      ackcnt_q <= ackcnt_d;
      ra_q     <= ra_d;
      rd_q     <= rd_d;
      wdata_q  <= wdata_d;
      redo_q   <= redo_d;
      we_q     <= we_d;
      conti_q  <= conti_d;
      fin_q    <= fin_d;
      err_q    <= err_d;
    end
  end

  assign tbl_addr    = idx_q;
  assign slave_addr  = SLAVE_ADDR;
  assign i2c_rw      = I2C_WR;
  assign i2c_begin   = (state_q == StBegin);
  assign conti_write = (state_q == StWait) && conti_q;
  assign write_data  = wdata_q;
  assign write_en    = we_q;
  assign busy        = !(state_q inside {StIdle, StDone, StErr});
  assign init_finish = fin_q;
  assign error       = err_q;
  assign err_index   = eidx_q;

endmodule

// File: tb/tb_i2c_init_seq.sv
// Randomized bench for i2c_init_seq: sync ROM model, master BFM with per-attempt
// response plans, and a transaction-level reference model of the retry rules.
module tb_i2c_init_seq;

  localparam int unsigned NUM_REGS   = 4;
  localparam int unsigned GAP_CYC    = 10;
  localparam int unsigned MAX_RETRY  = 3;
  localparam int unsigned TIMEOUT    = 40;
  localparam int unsigned AW         = 2;
  localparam logic [7:0]  SLAVE_ADDR = 8'h42;
  // Plan codes: -1 ack everything, 0..2 NACK that byte, 3 stall with no flags.
  localparam int PLAN_ACK   = -1;
  localparam int PLAN_STALL = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] tbl_addr;
  logic [15:0]   tbl_data = '0;
  logic [7:0]    slave_addr, write_data;
  logic          i2c_rw, i2c_begin, conti_write, write_en;
  logic          flag_start = 1'b0, flag_ack = 1'b0, flag_nack = 1'b0, flag_stop = 1'b0;
  logic          busy, init_finish, error;
  logic [AW-1:0] err_index;

  i2c_init_seq #(
    .SLAVE_ADDR(SLAVE_ADDR), .NUM_REGS(NUM_REGS), .GAP_CYC(GAP_CYC),
    .MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT), .AUTO_START(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .slave_addr(slave_addr), .i2c_rw(i2c_rw), .i2c_begin(i2c_begin),
    .conti_write(conti_write), .write_data(write_data), .write_en(write_en),
    .flag_start(flag_start), .flag_ack(flag_ack), .flag_nack(flag_nack),
    .flag_stop(flag_stop), .busy(busy), .init_finish(init_finish), .error(error),
    .err_index(err_index)
  );

  always #5 clk = ~clk;

  logic [15:0] rom [NUM_REGS];
  always @(posedge clk) tbl_data <= rom[tbl_addr];

  int n_checks = 0;
  int n_fails  = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed activity.
  int         beg_cyc[$];
  int         beg_idx[$];
  logic [7:0] got_wd[$];
  logic       got_ct[$];
  int         we_lag[$];
  int         stop_cyc[$];
  int         last_ack_cyc = -100;

  always @(negedge clk) begin
    if (rst_n) begin
      if (i2c_begin) begin
        beg_cyc.push_back(cyc);
        beg_idx.push_back(int'(tbl_addr));
      end
      if (write_en) begin
        got_wd.push_back(write_data);
        got_ct.push_back(conti_write);
        we_lag.push_back(cyc - last_ack_cyc);
      end
    end
  end

  task automatic clear_records();
    beg_cyc.delete(); beg_idx.delete(); got_wd.delete(); got_ct.delete();
    we_lag.delete(); stop_cyc.delete();
  endtask

  // Master BFM: one plan entry is consumed per i2c_begin.
  int plan_q[$];

  task automatic bfm_wait(input int n, output bit ok);
    repeat (n) @(negedge clk);
    ok = rst_n;
  endtask

  task automatic bfm_txn();
    int p;
    bit ok;
    p = (plan_q.size() > 0) ? plan_q.pop_front() : PLAN_ACK;
    if (p == PLAN_STALL) return;
    bfm_wait(int'($urandom_range(1, 3)), ok);
    if (!ok) return;
    flag_start = 1'b1; @(negedge clk); flag_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bfm_wait(int'($urandom_range(1, 3)), ok);
      if (!ok) return;
      if (k == p) begin
        flag_nack = 1'b1;
        flag_ack  = 1'($urandom_range(0, 1));  // ack alongside nack must lose
        @(negedge clk);
        flag_nack = 1'b0; flag_ack = 1'b0;
        return;
      end
      flag_ack = 1'b1; last_ack_cyc = cyc; @(negedge clk); flag_ack = 1'b0;
    end
    bfm_wait(int'($urandom_range(1, 3)), ok);
    if (!ok) return;
    flag_stop = 1'b1; stop_cyc.push_back(cyc); @(negedge clk); flag_stop = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && i2c_begin) bfm_txn();
    end
  end

  // Reference model: outcome of walking the table under a given response plan.
  int         model_plan[$];
  logic [7:0] exp_wd[$];
  logic       exp_ct[$];
  int         exp_beg[NUM_REGS];
  bit         exp_fin, exp_err;
  int         exp_eidx;

  task automatic model_run();
    int pl[$];
    int p, retries;
    pl = model_plan;
    exp_wd.delete(); exp_ct.delete();
    exp_fin = 0; exp_err = 0; exp_eidx = 0;
    foreach (exp_beg[i]) exp_beg[i] = 0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      retries = 0;
      forever begin
        p = (pl.size() > 0) ? pl.pop_front() : PLAN_ACK;
        exp_beg[i]++;
        if (p == PLAN_ACK || p == 1 || p == 2) begin
          exp_wd.push_back(rom[i][15:8]); exp_ct.push_back(1'b1);
        end
        if (p == PLAN_ACK || p == 2) begin
          exp_wd.push_back(rom[i][7:0]); exp_ct.push_back(1'b0);
        end
        if (p == PLAN_ACK) break;
        if (retries == int'(MAX_RETRY)) begin
          exp_err = 1; exp_eidx = i;
          return;
        end
        retries++;
      end
    end
    exp_fin = 1;
  endtask

  task automatic wait_idle(input int bound, output bit done);
    done = 0;
    for (int i = 0; i < bound && !done; i++) begin
      @(negedge clk);
      if ((init_finish || error) && !busy) done = 1;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, i2c_begin, write_en, conti_write, init_finish, error, i2c_rw} !== 7'b0) begin
      n_fails++;
      $display("FAIL reset_ctrl: got %b required 0000000", {busy, i2c_begin, write_en,
               conti_write, init_finish, error, i2c_rw});
    end
    n_checks++;
    if (write_data !== 8'h00 || tbl_addr !== '0 || err_index !== '0) begin
      n_fails++;
      $display("FAIL reset_data: wd=%02h addr=%0d eidx=%0d required 0,0,0",
               write_data, tbl_addr, err_index);
    end
    n_checks++;
    if (slave_addr !== SLAVE_ADDR) begin
      n_fails++;
      $display("FAIL reset_slave_addr: got %02h required %02h", slave_addr, SLAVE_ADDR);
    end
  endtask

  task automatic test_all_ack();
    bit done;
    int cnt[NUM_REGS];
    rom[0] = 16'h1280;
    rom[1] = 16'h3A04;
    for (int i = 2; i < int'(NUM_REGS); i++) rom[i] = 16'($urandom);
    model_plan.delete(); plan_q.delete(); model_run(); clear_records();
    @(negedge clk); rst_n = 1'b1;
    wait_idle(3000, done);
    n_checks++;
    if (!done) begin n_fails++; $display("FAIL all_ack_complete: finished=0 required 1"); end
    n_checks++;
    if (got_wd.size() != exp_wd.size()) begin
      n_fails++;
      $display("FAIL all_ack_nbytes: got %0d required %0d", got_wd.size(), exp_wd.size());
    end
    for (int i = 0; i < exp_wd.size() && i < got_wd.size(); i++) begin
      n_checks++;
      if (got_wd[i] !== exp_wd[i] || got_ct[i] !== exp_ct[i]) begin
        n_fails++;
        $display("FAIL all_ack_byte%0d: data=%02h conti=%0b required data=%02h conti=%0b",
                 i, got_wd[i], got_ct[i], exp_wd[i], exp_ct[i]);
      end
    end
    foreach (cnt[i]) cnt[i] = 0;
    foreach (beg_idx[i]) if (beg_idx[i] < int'(NUM_REGS)) cnt[beg_idx[i]]++;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      n_checks++;
      if (cnt[i] != exp_beg[i]) begin
        n_fails++;
        $display("FAIL all_ack_begins_idx%0d: got %0d required %0d", i, cnt[i], exp_beg[i]);
      end
    end
    n_checks++;
    if ({init_finish, error, busy} !== {exp_fin, exp_err, 1'b0}) begin
      n_fails++;
      $display("FAIL all_ack_status: fin/err/busy=%b required %b", {init_finish, error, busy},
               {exp_fin, exp_err, 1'b0});
    end
    foreach (we_lag[i]) begin
      n_checks++;
      if (we_lag[i] != 1) begin
        n_fails++;
        $display("FAIL write_en_lag%0d: got %0d cycles after ack required 1", i, we_lag[i]);
      end
    end
  endtask

  // Uses the records left by test_all_ack.
  task automatic test_gap();
    int d;
    for (int i = 0; i < int'(NUM_REGS) - 1; i++) begin
      d = (i < stop_cyc.size() && i + 1 < beg_cyc.size()) ? beg_cyc[i+1] - stop_cyc[i] : -1;
      n_checks++;
      if (d != int'(GAP_CYC) + 2) begin
        n_fails++;
        $display("FAIL gap_stop_to_begin%0d: got %0d cycles required %0d", i, d, GAP_CYC + 2);
      end
    end
  endtask

  task automatic test_nack_retry();
    bit done;
    int cnt[NUM_REGS];
    int nf;
    for (int i = 0; i < int'(NUM_REGS); i++) rom[i] = 16'($urandom);
    model_plan.delete();
    model_plan.push_back(0); model_plan.push_back(0); model_plan.push_back(PLAN_ACK);
    for (int i = 1; i < int'(NUM_REGS); i++) begin
      nf = int'($urandom_range(0, MAX_RETRY));
      repeat (nf) model_plan.push_back(int'($urandom_range(0, 2)));
      model_plan.push_back(PLAN_ACK);
    end
    plan_q = model_plan; model_run(); clear_records();
    pulse_start();
    repeat (5) @(negedge clk);
    pulse_start();  // while busy: must not restart
    wait_idle(5000, done);
    n_checks++;
    if (!done) begin n_fails++; $display("FAIL nack_complete: finished=0 required 1"); end
    n_checks++;
    if (got_wd.size() != exp_wd.size()) begin
      n_fails++;
      $display("FAIL nack_nbytes: got %0d required %0d", got_wd.size(), exp_wd.size());
    end
    for (int i = 0; i < exp_wd.size() && i < got_wd.size(); i++) begin
      n_checks++;
      if (got_wd[i] !== exp_wd[i] || got_ct[i] !== exp_ct[i]) begin
        n_fails++;
        $display("FAIL nack_byte%0d: data=%02h conti=%0b required data=%02h conti=%0b",
                 i, got_wd[i], got_ct[i], exp_wd[i], exp_ct[i]);
      end
    end
    foreach (cnt[i]) cnt[i] = 0;
    foreach (beg_idx[i]) if (beg_idx[i] < int'(NUM_REGS)) cnt[beg_idx[i]]++;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      n_checks++;
      if (cnt[i] != exp_beg[i]) begin
        n_fails++;
        $display("FAIL nack_begins_idx%0d: got %0d required %0d", i, cnt[i], exp_beg[i]);
      end
    end
    n_checks++;
    if ({init_finish, error} !== {exp_fin, exp_err}) begin
      n_fails++;
      $display("FAIL nack_status: fin/err=%b required %b", {init_finish, error},
               {exp_fin, exp_err});
    end
  endtask

  task automatic test_retry_exhaust();
    bit done;
    int cnt[NUM_REGS];
    for (int i = 0; i < int'(NUM_REGS); i++) rom[i] = 16'($urandom);
    model_plan.delete();
    model_plan.push_back(PLAN_ACK);
    repeat (MAX_RETRY + 1) model_plan.push_back(int'($urandom_range(0, 2)));
    plan_q = model_plan; model_run(); clear_records();
    pulse_start();
    wait_idle(5000, done);
    foreach (cnt[i]) cnt[i] = 0;
    foreach (beg_idx[i]) if (beg_idx[i] < int'(NUM_REGS)) cnt[beg_idx[i]]++;
    n_checks++;
    if (!done || cnt[1] != exp_beg[1]) begin
      n_fails++;
      $display("FAIL exhaust_begins_idx1: done=%0b got %0d required %0d", done, cnt[1],
               exp_beg[1]);
    end
    n_checks++;
    if ({init_finish, error, busy} !== {exp_fin, exp_err, 1'b0} ||
        int'(err_index) != exp_eidx) begin
      n_fails++;
      $display("FAIL exhaust_status: fin/err/busy=%b eidx=%0d required %b eidx=%0d",
               {init_finish, error, busy}, err_index, {exp_fin, exp_err, 1'b0}, exp_eidx);
    end
    n_checks++;
    if (got_wd.size() != exp_wd.size()) begin
      n_fails++;
      $display("FAIL exhaust_nbytes: got %0d required %0d", got_wd.size(), exp_wd.size());
    end
    // Restart from ERR: whole table again from entry 0.
    model_plan.delete(); plan_q.delete(); model_run(); clear_records();
    pulse_start();
    wait_idle(3000, done);
    n_checks++;
    if (!done || beg_idx.size() != int'(NUM_REGS) || beg_idx[0] != 0) begin
      n_fails++;
      $display("FAIL rerun_begins: done=%0b count=%0d required count=%0d from idx 0",
               done, beg_idx.size(), NUM_REGS);
    end
    n_checks++;
    if ({init_finish, error} !== 2'b10) begin
      n_fails++;
      $display("FAIL rerun_status: fin/err=%b required 10", {init_finish, error});
    end
  endtask

  task automatic test_timeout();
    bit done;
    int d;
    int cnt[NUM_REGS];
    model_plan.delete();
    model_plan.push_back(PLAN_STALL);
    repeat (MAX_RETRY) model_plan.push_back(0);
    plan_q = model_plan; model_run(); clear_records();
    pulse_start();
    wait_idle(5000, done);
    // begin, TIMEOUT cycles of WAIT, FAIL, GAP_CYC gap cycles, FETCH, begin
    d = (beg_cyc.size() >= 2) ? beg_cyc[1] - beg_cyc[0] : -1;
    n_checks++;
    if (d != int'(TIMEOUT + GAP_CYC) + 3) begin
      n_fails++;
      $display("FAIL timeout_retry_spacing: got %0d cycles required %0d", d,
               TIMEOUT + GAP_CYC + 3);
    end
    foreach (cnt[i]) cnt[i] = 0;
    foreach (beg_idx[i]) if (beg_idx[i] < int'(NUM_REGS)) cnt[beg_idx[i]]++;
    n_checks++;
    if (!done || cnt[0] != exp_beg[0] || {error, init_finish} !== {exp_err, exp_fin} ||
        int'(err_index) != exp_eidx) begin
      n_fails++;
      $display("FAIL timeout_counts_retry: begins=%0d err=%0b eidx=%0d required %0d,%0b,%0d",
               cnt[0], error, err_index, exp_beg[0], exp_err, exp_eidx);
    end
  endtask

  task automatic test_reset_mid();
    bit done, hit;
    for (int i = 0; i < int'(NUM_REGS); i++) rom[i] = 16'($urandom);
    rom[1] = rom[1] | 16'h0100;
    model_plan.delete(); plan_q.delete();
    pulse_start();
    hit = 0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      @(negedge clk);
      if (write_en && tbl_addr == 2'd1) hit = 1;
    end
    n_checks++;
    if (!hit) begin n_fails++; $display("FAIL midreset_reach_wait: reached=0 required 1"); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, i2c_begin, write_en, conti_write, init_finish, error} !== 6'b0 ||
        write_data !== 8'h00 || tbl_addr !== '0) begin
      n_fails++;
      $display("FAIL midreset_async: ctrl=%b wd=%02h addr=%0d required 000000,00,0",
               {busy, i2c_begin, write_en, conti_write, init_finish, error}, write_data,
               tbl_addr);
    end
    repeat (6) @(negedge clk);
    model_run(); clear_records();
    rst_n = 1'b1;
    wait_idle(3000, done);
    n_checks++;
    if (!done || beg_idx.size() == 0 || beg_idx[0] != 0 || init_finish !== 1'b1) begin
      n_fails++;
      $display("FAIL midreset_resume: done=%0b first_idx=%0d fin=%0b required 1,0,1", done,
               (beg_idx.size() > 0) ? beg_idx[0] : -1, init_finish);
    end
    n_checks++;
    if (got_wd != exp_wd) begin
      n_fails++;
      $display("FAIL midreset_bytes: got %0d bytes required %0d matching bytes", got_wd.size(),
               exp_wd.size());
    end
  endtask

  initial begin
    test_reset();
    test_all_ack();
    test_gap();
    test_nack_retry();
    test_retry_exhaust();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t required finished", $time);
    $fatal(1, "watchdog");
  end

endmodule
